// File: rtl/bsg_cycle_counter_reset_chain_if.sv
// bsg_cycle_counter_reset_chain_if: tag-done input and delayed reset / cycle count outputs
// master: drives tag_done_i, observes reset_o and ctr_r_o (host or bench side)
// slave : receives tag_done_i, drives reset_o and ctr_r_o (reset chain side)
interface bsg_cycle_counter_reset_chain_if #(parameter int width_p = 32);
  logic               tag_done_i;
  logic               reset_o;
  logic [width_p-1:0] ctr_r_o;
  modport master (output tag_done_i, input reset_o, ctr_r_o);
  modport slave (input tag_done_i, output reset_o, ctr_r_o);
endinterface

// File: rtl/bsg_cycle_counter_reset_chain.sv
// bsg_cycle_counter_reset_chain: delays ~tag_done through a flop chain into reset_o and counts cycles since release
// clk_i   : rising-edge clock
// reset_i : synchronous active-high reset, forces every stage to 1 and the counter to 0
// bus     : tag_done_i in; reset_o (~tag_done_i delayed num_stages_p cycles) and ctr_r_o out
module bsg_cycle_counter_reset_chain #(
  parameter int width_p      = 32,
  parameter int num_stages_p = 3
) (
  input logic clk_i,
  input logic reset_i,
  bsg_cycle_counter_reset_chain_if.slave bus
);
  logic               w_reset;
  logic [width_p-1:0] r_ctr;
  if (num_stages_p > 0) begin : g_chain
    logic [num_stages_p-1:0] r_stage;
    always_ff @(posedge clk_i) begin
      if (reset_i) r_stage <= '1;
      else begin
        r_stage[0] <= ~bus.tag_done_i;
        for (int k = 1; k < num_stages_p; k++) r_stage[k] <= r_stage[k-1];
      end
    end
    assign w_reset = r_stage[num_stages_p-1];
  end else begin : g_comb
    // no chain flops: reset_i must still reach reset_o combinationally
    assign w_reset = reset_i | ~bus.tag_done_i;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i || w_reset) r_ctr <= '0;
    else r_ctr <= r_ctr + width_p'(1);
  end
  assign bus.reset_o = w_reset;
  assign bus.ctr_r_o = r_ctr;
endmodule

// File: tb/tb_bsg_cycle_counter_reset_chain.sv
// tb_bsg_cycle_counter_reset_chain: scoreboard bench over three configurations of the reset chain
`timescale 1ps/1ps
module tb_bsg_cycle_counter_reset_chain;
  typedef struct {
    int          sel;
    logic        er;
    logic [31:0] ec;
    string       nm;
  } item_t;

  logic clk = 1'b0;
  logic ra = 1'b1, rb = 1'b1, rc = 1'b1;
  item_t q[$];
  item_t it;
  int total = 0, bad = 0;
  logic        act_r;
  logic [31:0] act_c;

  always #500 clk = ~clk;

  bsg_cycle_counter_reset_chain_if #(.width_p(32)) ifa ();
  bsg_cycle_counter_reset_chain_if #(.width_p(4))  ifb ();
  bsg_cycle_counter_reset_chain_if #(.width_p(8))  ifc ();

  bsg_cycle_counter_reset_chain #(.width_p(32), .num_stages_p(3)) dut_a (.clk_i(clk), .reset_i(ra), .bus(ifa.slave));
  bsg_cycle_counter_reset_chain #(.width_p(4),  .num_stages_p(3)) dut_b (.clk_i(clk), .reset_i(rb), .bus(ifb.slave));
  bsg_cycle_counter_reset_chain #(.width_p(8),  .num_stages_p(0)) dut_c (.clk_i(clk), .reset_i(rc), .bus(ifc.slave));

  initial begin
    ifa.tag_done_i = 1'b0;
    ifb.tag_done_i = 1'b0;
    ifc.tag_done_i = 1'b0;
  end

  // drive one cycle of stimulus and queue what the selected DUT must show after the next edge
  task automatic step(input int sel, input logic rst, input logic tag, input logic er, input logic [31:0] ec, input string nm);
    @(negedge clk);
    if (sel == 0) begin ra = rst; ifa.tag_done_i = tag; end
    else if (sel == 1) begin rb = rst; ifb.tag_done_i = tag; end
    else begin rc = rst; ifc.tag_done_i = tag; end
    q.push_back('{sel: sel, er: er, ec: ec, nm: nm});
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      it = q.pop_front();
      act_r = it.sel == 0 ? ifa.reset_o : it.sel == 1 ? ifb.reset_o : ifc.reset_o;
      act_c = it.sel == 0 ? ifa.ctr_r_o : it.sel == 1 ? 32'(ifb.ctr_r_o) : 32'(ifc.ctr_r_o);
      total++;
      if (act_r !== it.er || act_c !== it.ec) begin
        bad++;
        $display("FAIL %s: got reset_o=%b ctr=%0d, expected reset_o=%b ctr=%0d", it.nm, act_r, act_c, it.er, it.ec);
      end
    end
  end

  initial begin
    // N=3 w=32: reset hold, then tag still low
    for (int i = 0; i < 16; i++) step(0, 1, 0, 1, 0, "a_reset");
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, "a_tag_low");
    // release: reset_o drops after E2, count starts after E3
    for (int i = 0; i < 20; i++) step(0, 0, 1, i < 2, i < 3 ? 0 : 32'(i - 2), "a_release");
    // one-cycle tag drop at ctr=17
    step(0, 0, 0, 0, 18, "a_glitch1_f0");
    step(0, 0, 1, 0, 19, "a_glitch1_f1");
    step(0, 0, 1, 1, 20, "a_glitch1_f2");
    step(0, 0, 1, 0, 0,  "a_glitch1_f3");
    step(0, 0, 1, 0, 1,  "a_glitch1_f4");
    step(0, 0, 1, 0, 2,  "a_glitch1_f5");
    // two-cycle tag drop: same-width pulse 3 cycles later
    step(0, 0, 0, 0, 3, "a_glitch2_h0");
    step(0, 0, 0, 0, 4, "a_glitch2_h1");
    step(0, 0, 1, 1, 5, "a_glitch2_h2");
    step(0, 0, 1, 1, 0, "a_glitch2_h3");
    step(0, 0, 1, 0, 0, "a_glitch2_h4");
    step(0, 0, 1, 0, 1, "a_glitch2_h5");
    for (int v = 2; v <= 100; v++) step(0, 0, 1, 0, 32'(v), "a_count");
    // reset_i pulse with tag high: reset wins, release restarts
    step(0, 1, 1, 1, 0, "a_midreset");
    step(0, 0, 1, 1, 0, "a_rerelease_g0");
    step(0, 0, 1, 1, 0, "a_rerelease_g1");
    step(0, 0, 1, 0, 0, "a_rerelease_g2");
    step(0, 0, 1, 0, 1, "a_rerelease_g3");
    step(0, 0, 1, 0, 2, "a_rerelease_g4");
    // N=3 w=4: wrap 15 -> 0 with no stall
    step(1, 1, 0, 1, 0, "b_reset");
    step(1, 1, 0, 1, 0, "b_reset");
    for (int i = 0; i < 40; i++) step(1, 0, 1, i < 2, i < 3 ? 0 : 32'((i - 2) % 16), "b_wrap");
    // N=0: reset_o follows ~tag combinationally, counter clears on the edge
    step(2, 1, 0, 1, 0, "c_reset");
    step(2, 1, 1, 1, 0, "c_reset_wins");
    step(2, 0, 1, 0, 1, "c_count");
    step(2, 0, 1, 0, 2, "c_count");
    step(2, 0, 1, 0, 3, "c_count");
    step(2, 0, 0, 1, 0, "c_tag_low");
    step(2, 0, 0, 1, 0, "c_tag_low");
    step(2, 0, 1, 0, 1, "c_recount");
    step(2, 0, 1, 0, 2, "c_recount");
    repeat (2) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
